// File: rtl/riscv_data_bus.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_data_bus
//  Purpose  : LSU-to-slaves data interconnect with address decode,
//             registered request/ready handshake, timeout and error response.
//  Revision : 1.0 - initial release
// ============================================================================

module riscv_data_bus #(
    parameter int          N_SLV    = 4,
    parameter int          TIMEOUT  = 16,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,

    input  logic                 m_req_i,
    input  logic                 m_we_i,
    input  logic [3:0]           m_be_i,
    input  logic [31:0]          m_addr_i,
    input  logic [31:0]          m_wd_i,
    output logic [31:0]          m_rd_o,
    output logic                 m_ready_o,
    output logic                 m_err_o,

    output logic [N_SLV-1:0]     s_req_o,
    output logic                 s_we_o,
    output logic [3:0]           s_be_o,
    output logic [31:0]          s_addr_o,
    output logic [31:0]          s_wd_o,
    input  logic [N_SLV*32-1:0]  s_rd_i,
    input  logic [N_SLV-1:0]     s_ready_i
);

    localparam int c_sel_w = (N_SLV > 1) ? $clog2(N_SLV) : 1;
    localparam int c_cnt_w = $clog2(TIMEOUT + 1);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_access = 2'd1;
    localparam logic [1:0] c_st_resp   = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_sel_w-1:0] r_sel;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_err;
    logic [31:0]        r_rd;
    logic [N_SLV-1:0]   r_sreq;
    logic               r_we;
    logic [3:0]         r_be;
    logic [31:0]        r_addr;
    logic [31:0]        r_wd;

    logic [7:0]         w_sel;
    logic               w_mapped;
    logic [N_SLV-1:0]   w_onehot;
    logic               w_slv_ready;
    logic [31:0]        w_slv_rd;
    logic               w_timeout;

    assign w_sel     = m_addr_i[31:24];
    assign w_mapped  = (32'(w_sel) < N_SLV);
    assign w_timeout = (r_cnt == c_cnt_w'(TIMEOUT - 1));

    always_comb begin
        w_onehot = '0;
        for (int k = 0; k < N_SLV; k++) begin
            w_onehot[k] = (w_sel == 8'(k));
        end
    end

    // Only the latched slave's ready/data are visible; other slaves are ignored.
    always_comb begin
        w_slv_ready = 1'b0;
        w_slv_rd    = '0;
        for (int k = 0; k < N_SLV; k++) begin
            if (r_sel == c_sel_w'(k)) begin
                w_slv_ready = s_ready_i[k];
                w_slv_rd    = s_rd_i[k*32 +: 32];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (m_req_i) begin
                    w_state_nxt = w_mapped ? c_st_access : c_st_resp;
                end
            end
            c_st_access: begin
                if (w_slv_ready || w_timeout) begin
                    w_state_nxt = c_st_resp;
                end
            end
            c_st_resp: begin
                w_state_nxt = c_st_idle;
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sel  <= '0;
            r_cnt  <= '0;
            r_err  <= 1'b0;
            r_rd   <= '0;
            r_sreq <= '0;
            r_we   <= 1'b0;
            r_be   <= '0;
            r_addr <= '0;
            r_wd   <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (m_req_i) begin
                        r_we   <= m_we_i;
                        r_be   <= m_be_i;
                        r_addr <= m_addr_i;
                        r_wd   <= m_wd_i;
                        r_sel  <= w_sel[c_sel_w-1:0];
                        r_cnt  <= '0;
                        if (w_mapped) begin
                            r_sreq <= w_onehot;
                        end else begin
                            r_err <= 1'b1;
                            r_rd  <= ERR_DATA;
                        end
                    end
                end
                c_st_access: begin
                    r_cnt <= r_cnt + c_cnt_w'(1);
                    // Ready on the limit cycle takes priority over the timeout.
                    if (w_slv_ready) begin
                        r_sreq <= '0;
                        r_err  <= 1'b0;
                        r_rd   <= w_slv_rd;
                    end else if (w_timeout) begin
                        r_sreq <= '0;
                        r_err  <= 1'b1;
                        r_rd   <= ERR_DATA;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign m_ready_o = (r_state == c_st_resp);
    assign m_err_o   = m_ready_o & r_err;
    assign m_rd_o    = r_rd;
    assign s_req_o   = r_sreq;
    assign s_we_o    = r_we;
    assign s_be_o    = r_be;
    assign s_addr_o  = r_addr;
    assign s_wd_o    = r_wd;

endmodule

`default_nettype wire
